// File: rtl/wb_pkg.sv
// Shared Wishbone B3 definitions for the burst RAM slave.
//   CTI_* : cycle type identifier codes (cti_i)
//   BTE_* : burst type extension codes (bte_i)
//   state_e : slave FSM states
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_BURST,
    ST_ERR
  } state_e;

endpackage

// File: rtl/wb_burst_addr.sv
// Combinational next-beat word index for incrementing bursts.
//   baddr_i  : current beat word index
//   bte_i    : burst type (linear / wrap-4 / wrap-8 / wrap-16)
//   next_c_o : word index of the following beat
module wb_burst_addr
  import wb_pkg::*;
#(
  parameter int unsigned IDX_W = 18
) (
  input  logic [IDX_W-1:0] baddr_i,
  input  logic [1:0]       bte_i,
  output logic [IDX_W-1:0] next_c_o
);

  logic [IDX_W-1:0] wmask;
  logic [IDX_W-1:0] inc;

  // Bits under wmask take the incremented value, the rest are held.
  always_comb begin
    wmask = '1;
    case (bte_i)
      BTE_WRAP4:  wmask = IDX_W'(3);
      BTE_WRAP8:  wmask = IDX_W'(7);
      BTE_WRAP16: wmask = IDX_W'(15);
      default:    wmask = '1;
    endcase
    inc      = baddr_i + IDX_W'(1);
    next_c_o = (baddr_i & ~wmask) | (inc & wmask);
  end

endmodule

// File: rtl/wb_burst_ram.sv
// Wishbone B3 single-port RAM slave with wait states, registered-feedback
// incrementing bursts (linear, wrap-4/8/16) and out-of-range error cycles.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cyc_i, stb_i, we_i  : bus cycle, strobe, write enable
//   adr_i, dat_i, sel_i : byte address, write data, byte lanes
//   cti_i, bte_i        : cycle type, burst type
//   dat_o, ack_o, err_o : read data, normal and error termination
module wb_burst_ram
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned SEL_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned MEM_WORDS   = 2 ** (ADDR_WIDTH - $clog2(SEL_WIDTH)),
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic [2:0]            cti_i,
  input  logic [1:0]            bte_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  err_o
);

  localparam int unsigned LSB_W  = $clog2(SEL_WIDTH);
  localparam int unsigned IDX_W  = ADDR_WIDTH - LSB_W;
  localparam int unsigned MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam logic [IDX_W:0] MEM_LIMIT = (IDX_W + 1)'(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  state_e                state_q, state_d;
  state_e                tgt_q, tgt_d;
  state_e                req_tgt;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      baddr_q, baddr_d;
  logic [IDX_W-1:0]      baddr_next_c;
  logic [DATA_WIDTH-1:0] dat_q;

  logic [IDX_W-1:0]      adr_idx;
  logic                  adr_oor;
  logic                  baddr_oor;
  logic                  beat_ok;
  logic                  req;
  logic                  in_burst;
  logic                  rd_en;
  logic [MEM_AW-1:0]     rd_idx;

  if (LSB_W > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^adr_i[LSB_W-1:0];
  end

  assign adr_idx   = adr_i[ADDR_WIDTH-1:LSB_W];
  assign adr_oor   = {1'b0, adr_idx} >= MEM_LIMIT;
  assign baddr_oor = {1'b0, baddr_q} >= MEM_LIMIT;
  assign req       = cyc_i & stb_i;
  assign in_burst  = (state_q == ST_BURST);
  // A burst beat is only good if the master follows our address sequence.
  assign beat_ok   = (adr_idx == baddr_q) && !baddr_oor;

  // Terminations are decoded from registered state, then qualified by the bus.
  assign ack_o = req & ((state_q == ST_ACK) | (in_burst & beat_ok));
  assign err_o = req & ((state_q == ST_ERR) | (in_burst & ~beat_ok));
  assign dat_o = dat_q;

  wb_burst_addr #(
    .IDX_W(IDX_W)
  ) u_addr (
    .baddr_i (baddr_q),
    .bte_i   (bte_i),
    .next_c_o(baddr_next_c)
  );

  // Where a fresh request ends up once the wait states have elapsed.
  always_comb begin
    req_tgt = ST_ACK;
    if (adr_oor) begin
      req_tgt = ST_ERR;
    end else if (cti_i == CTI_INCR) begin
      req_tgt = ST_BURST;
    end
  end

  // Next-state logic; also chooses which word gets prefetched into dat_q.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    baddr_d = baddr_q;
    rd_en   = 1'b0;
    rd_idx  = adr_idx[MEM_AW-1:0];
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = req_tgt;
            rd_en   = 1'b1;
            if (req_tgt == ST_BURST) baddr_d = adr_idx;
          end else begin
            state_d = ST_WAIT;
            tgt_d   = req_tgt;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        if (!cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(WAIT_STATES - 1)) begin
          state_d = tgt_q;
          cnt_d   = '0;
          rd_en   = 1'b1;
          if (tgt_q == ST_BURST) baddr_d = adr_idx;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BURST: begin
        if (!cyc_i) begin
          state_d = ST_IDLE;
        end else if (stb_i) begin
          if (beat_ok && (cti_i == CTI_INCR)) begin
            baddr_d = baddr_next_c;
            rd_en   = 1'b1;
            rd_idx  = baddr_next_c[MEM_AW-1:0];
          end else begin
            // End of burst, error beat, or a non-burst code all close the burst.
            state_d = ST_IDLE;
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= ST_IDLE;
      cnt_q   <= '0;
      baddr_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      baddr_q <= baddr_d;
    end
  end

  // Read data register, loaded one edge ahead of the beat it serves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_q <= '0;
    end else if (rd_en) begin
      dat_q <= mem[rd_idx];
    end
  end

  // Byte-lane writes; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (ack_o && we_i) begin
      for (int k = 0; k < int'(SEL_WIDTH); k++) begin
        if (sel_i[k]) mem[adr_idx[MEM_AW-1:0]][k*8 +: 8] <= dat_i[k*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_ram.sv
// Directed bench for wb_burst_ram: zero-wait instance (dut0) and a
// three-wait, 256-word instance (dut1) sharing all inputs except cyc.
module tb_wb_burst_ram;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc0 = 1'b0, cyc1 = 1'b0, stb = 1'b0, we = 1'b0;
  logic [19:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] dat0, dat1;
  logic        ack0, err0, ack1, err1;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  wb_burst_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(20), .MEM_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cyc_i(cyc0), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(wdat), .sel_i(sel), .cti_i(cti), .bte_i(bte),
    .dat_o(dat0), .ack_o(ack0), .err_o(err0));

  wb_burst_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(20), .MEM_WORDS(256), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .cyc_i(cyc1), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(wdat), .sel_i(sel), .cti_i(cti), .bte_i(bte),
    .dat_o(dat1), .ack_o(ack1), .err_o(err1));

  typedef struct {
    logic        we;
    logic [19:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // {ack, err} of the selected instance
  function automatic logic [1:0] resp(input int d);
    return (d == 0) ? {ack0, err0} : {ack1, err1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input int d, input string name, input logic [1:0] er,
                             input logic cd, input logic [31:0] ed);
    @(negedge clk);
    chk(name, 32'(resp(d)), 32'(er));
    if (cd) chk({name, " data"}, (d == 0) ? dat0 : dat1, ed);
  endtask

  task automatic drive(input int d, input logic w, input logic [19:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input logic [2:0] c, input logic [1:0] b);
    cyc0 = (d == 0); cyc1 = (d != 0); stb = 1'b1;
    we = w; adr = a; wdat = wd; sel = s; cti = c; bte = b;
  endtask

  task automatic release_bus();
    cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
  endtask

  // Single classic cycle with exact latency check and trailing idle check.
  task automatic classic(input int d, input logic w, input logic [19:0] a, input logic [31:0] wd,
                         input logic [3:0] s, input logic exp_err, input logic [31:0] exp_d,
                         input string name);
    int ws;
    ws = (d == 0) ? 0 : 3;
    step();
    drive(d, w, a, wd, s, CTI_CLASSIC, BTE_LINEAR);
    for (int k = 0; k <= ws; k++) expect_resp(d, {name, " wait"}, 2'b00, 1'b0, '0);
    expect_resp(d, {name, " term"}, exp_err ? 2'b01 : 2'b10, !w && !exp_err, exp_d);
    step();
    release_bus();
    expect_resp(d, {name, " idle"}, 2'b00, 1'b0, '0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 20'h0000C, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b1, 20'h00010, 32'hAABBCCDD, 4'hF, 32'h0};
    vecs[2]  = '{1'b0, 20'h0000C, 32'h0,        4'hF, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 20'h00010, 32'h11223344, 4'h5, 32'h0};
    vecs[4]  = '{1'b0, 20'h00010, 32'h0,        4'hF, 32'hAA22CC44};
    vecs[5]  = '{1'b1, 20'h00014, 32'h55555555, 4'hF, 32'h0};
    vecs[6]  = '{1'b1, 20'h00018, 32'h66666666, 4'hF, 32'h0};
    vecs[7]  = '{1'b1, 20'h0001C, 32'h77777777, 4'hF, 32'h0};
    vecs[8]  = '{1'b1, 20'h0001C, 32'hEE123456, 4'h8, 32'h0};
    vecs[9]  = '{1'b0, 20'h0001C, 32'h0,        4'hF, 32'hEE777777};
    vecs[10] = '{1'b0, 20'h00014, 32'h0,        4'hF, 32'h55555555};
    vecs[11] = '{1'b1, 20'h00034, 32'h13131313, 4'hF, 32'h0};
    vecs[12] = '{1'b1, 20'h00038, 32'h14141414, 4'hF, 32'h0};
    vecs[13] = '{1'b1, 20'h00040, 32'h00000000, 4'hF, 32'h0};
    vecs[14] = '{1'b1, 20'h00044, 32'h17171717, 4'hF, 32'h0};

    // Reset values
    @(negedge clk);
    chk("rst resp0", 32'(resp(0)), 32'h0);
    chk("rst resp1", 32'(resp(1)), 32'h0);
    chk("rst dat0", dat0, 32'h0);
    chk("rst dat1", dat1, 32'h0);
    step();
    rst_n = 1'b1;

    // Classic vectors on the zero-wait instance
    for (int i = 0; i < 15; i++)
      classic(0, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, 1'b0, vecs[i].exp,
              $sformatf("vec%0d", i));

    // Back-to-back classic reads: ack, idle, ack
    step();
    drive(0, 1'b0, 20'h0000C, '0, 4'hF, CTI_CLASSIC, BTE_LINEAR);
    expect_resp(0, "b2b pre", 2'b00, 1'b0, '0);
    step();
    expect_resp(0, "b2b ack1", 2'b10, 1'b1, 32'hDEADBEEF);
    step();
    expect_resp(0, "b2b gap", 2'b00, 1'b0, '0);
    step();
    expect_resp(0, "b2b ack2", 2'b10, 1'b1, 32'hDEADBEEF);
    step();
    release_bus();
    expect_resp(0, "b2b idle", 2'b00, 1'b0, '0);

    // Wrap-4 read burst from word 6: words 6,7,4,5
    begin
      logic [19:0] wa [4];
      logic [31:0] wd [4];
      wa = '{20'h18, 20'h1C, 20'h10, 20'h14};
      wd = '{32'h66666666, 32'hEE777777, 32'hAA22CC44, 32'h55555555};
      step();
      drive(0, 1'b0, wa[0], '0, 4'hF, CTI_INCR, BTE_WRAP4);
      expect_resp(0, "wrap pre", 2'b00, 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
        step();
        if (i > 0) begin
          adr = wa[i];
          cti = (i == 3) ? CTI_EOB : CTI_INCR;
        end
        expect_resp(0, $sformatf("wrap beat%0d", i), 2'b10, 1'b1, wd[i]);
      end
      step();
      release_bus();
      expect_resp(0, "wrap end", 2'b00, 1'b0, '0);
    end

    // Linear write burst words 8..11 with a two-cycle master stall
    step();
    drive(0, 1'b1, 20'h20, 32'hD8D8D8D8, 4'hF, CTI_INCR, BTE_LINEAR);
    expect_resp(0, "lin pre", 2'b00, 1'b0, '0);
    step();
    expect_resp(0, "lin beat0", 2'b10, 1'b0, '0);
    step();
    adr = 20'h24; wdat = 32'hD9D9D9D9;
    expect_resp(0, "lin beat1", 2'b10, 1'b0, '0);
    step();
    stb = 1'b0;
    expect_resp(0, "lin stall0", 2'b00, 1'b0, '0);
    step();
    expect_resp(0, "lin stall1", 2'b00, 1'b0, '0);
    step();
    stb = 1'b1; adr = 20'h28; wdat = 32'hDADADADA;
    expect_resp(0, "lin beat2", 2'b10, 1'b0, '0);
    step();
    adr = 20'h2C; wdat = 32'hDBDBDBDB; cti = CTI_EOB;
    expect_resp(0, "lin beat3", 2'b10, 1'b0, '0);
    step();
    release_bus();
    expect_resp(0, "lin end", 2'b00, 1'b0, '0);
    classic(0, 1'b0, 20'h20, '0, 4'hF, 1'b0, 32'hD8D8D8D8, "lin rd8");
    classic(0, 1'b0, 20'h24, '0, 4'hF, 1'b0, 32'hD9D9D9D9, "lin rd9");
    classic(0, 1'b0, 20'h28, '0, 4'hF, 1'b0, 32'hDADADADA, "lin rd10");
    classic(0, 1'b0, 20'h2C, '0, 4'hF, 1'b0, 32'hDBDBDBDB, "lin rd11");

    // Address mismatch on the second beat of a write burst
    step();
    drive(0, 1'b1, 20'h30, 32'hC0C0C0C0, 4'hF, CTI_INCR, BTE_LINEAR);
    expect_resp(0, "mis pre", 2'b00, 1'b0, '0);
    step();
    expect_resp(0, "mis beat0", 2'b10, 1'b0, '0);
    step();
    adr = 20'h38; wdat = 32'hBADBAD00;
    expect_resp(0, "mis beat1 err", 2'b01, 1'b0, '0);
    step();
    expect_resp(0, "mis after", 2'b00, 1'b0, '0);
    release_bus();
    classic(0, 1'b0, 20'h30, '0, 4'hF, 1'b0, 32'hC0C0C0C0, "mis rd12");
    classic(0, 1'b0, 20'h34, '0, 4'hF, 1'b0, 32'h13131313, "mis rd13");
    classic(0, 1'b0, 20'h38, '0, 4'hF, 1'b0, 32'h14141414, "mis rd14");

    // Reset during the second beat of a write burst
    step();
    drive(0, 1'b1, 20'h40, 32'h16A0A0A0, 4'hF, CTI_INCR, BTE_LINEAR);
    expect_resp(0, "rst pre", 2'b00, 1'b0, '0);
    step();
    expect_resp(0, "rst beat0", 2'b10, 1'b0, '0);
    step();
    adr = 20'h44; wdat = 32'h17B0B0B0; cti = CTI_EOB;
    expect_resp(0, "rst beat1", 2'b10, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async resp", 32'(resp(0)), 32'h0);
    chk("rst async dat", dat0, 32'h0);
    step();
    release_bus();
    rst_n = 1'b1;
    classic(0, 1'b0, 20'h40, '0, 4'hF, 1'b0, 32'h16A0A0A0, "rst rd16");
    classic(0, 1'b0, 20'h44, '0, 4'hF, 1'b0, 32'h17171717, "rst rd17");

    // Three-wait, 256-word instance: latency, range errors, abort
    classic(1, 1'b1, 20'h000B0, 32'h44444444, 4'hF, 1'b0, '0, "ws3 wr44");
    classic(1, 1'b0, 20'h000B0, '0, 4'hF, 1'b0, 32'h44444444, "ws3 rd44");
    classic(1, 1'b0, 20'h004B0, '0, 4'hF, 1'b1, '0, "ws3 rd300 err");
    classic(1, 1'b1, 20'h004B0, 32'hBAD00BAD, 4'hF, 1'b1, '0, "ws3 wr300 err");
    classic(1, 1'b0, 20'h000B0, '0, 4'hF, 1'b0, 32'h44444444, "ws3 rd44 kept");
    classic(1, 1'b1, 20'h000B4, 32'h45454545, 4'hF, 1'b0, '0, "ws3 wr45");
    step();
    drive(1, 1'b1, 20'h000B4, 32'h99999999, 4'hF, CTI_CLASSIC, BTE_LINEAR);
    expect_resp(1, "abort pre", 2'b00, 1'b0, '0);
    step();
    expect_resp(1, "abort wait", 2'b00, 1'b0, '0);
    step();
    release_bus();
    for (int k = 0; k < 4; k++) expect_resp(1, "abort idle", 2'b00, 1'b0, '0);
    classic(1, 1'b0, 20'h000B4, '0, 4'hF, 1'b0, 32'h45454545, "abort rd45");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Both terminations must never coexist on either instance.
  always @(negedge clk) begin
    if ((ack0 && err0) || (ack1 && err1)) begin
      n_mis++;
      $display("FAIL ack_err_overlap: ack0=%b err0=%b ack1=%b err1=%b, want no overlap",
               ack0, err0, ack1, err1);
    end
  end

endmodule

// File: doc/wb_burst_ram.md
# wb_burst_ram

Parametrised Wishbone B3 single-port RAM slave. It is the successor to the fixed 32-bit classic-cycle RAM used behind the ao68000 core in the point-to-point test systems. Adds configurable data width and depth, programmable wait states, and registered-feedback incrementing bursts with linear and wrap-4/8/16 addressing. Also adds out-of-range error termination. It is intended as the memory model and boot RAM behind `ao68000` and future masters that drive `CTI_O`/`BTE_O`.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data bus width in bits; must be 8·2^k.
- `ADDR_WIDTH`, 20: byte-address width of `adr_i`.
- `SEL_WIDTH`, DATA_WIDTH/8: byte-lane count.
- `MEM_WORDS`, 2^(ADDR_WIDTH−log2(SEL_WIDTH)): implemented words; must be ≤ that maximum.
- `WAIT_STATES`, 0: extra cycles before the first acknowledge of any cycle (0..15).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`, in, 1: the single clock.
  - `rst_n`, in, 1: asynchronous, active-low reset.
- `cyc_i` in 1: bus cycle valid.
- `stb_i` in 1: strobe.
- `we_i` in 1: write enable.
- `adr_i` in ADDR_WIDTH: byte address; low log2(SEL_WIDTH) bits are ignored.
- `dat_i` in DATA_WIDTH: write data.
- `sel_i` in SEL_WIDTH: byte-lane enables.
- `cti_i` in 3: cycle type. 000 classic, 010 incrementing burst, 111 end of burst; other codes are treated as classic.
- `bte_i` in 2: burst type. 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- `dat_o` out DATA_WIDTH: read data; valid while `ack_o`=1.
- `ack_o` out 1: normal termination.
- `err_o` out 1: error termination.

## Operation
- Word index = `adr_i[ADDR_WIDTH-1:log2(SEL_WIDTH)]`. An index ≥ MEM_WORDS is out of range.
- FSM states:
  - IDLE: entered at reset.
  - WAIT: counting wait states.
  - ACK: classic beat.
  - BURST: streaming beats.
  - ERR: error beat.
- IDLE:
  - Samples `cyc_i&stb_i` at each edge.
  - Out of range: go to ERR after the wait count.
  - Otherwise: go to WAIT if WAIT_STATES>0, else straight to ACK or BURST.
  - Target is BURST when `cti_i`=010; otherwise ACK.
- WAIT:
  - Counts WAIT_STATES edges, then moves to the target state.
  - Request inputs are held by the master and not re-checked, except `cyc_i`.
- ACK:
  - `ack_o`=1 for one cycle, then IDLE.
  - Every classic cycle is followed by one idle cycle.
- BURST:
  - Internal beat address `baddr` is loaded from `adr_i` on entry.
  - Each completed beat (`stb_i&ack_o` at an edge) advances `baddr` by one word.
  - Wrap-N: the low log2(N) word-index bits increment modulo N; upper bits are held.
  - Linear: full increment.
  - A beat with `cti_i`=111 completes the burst; state returns to IDLE.
  - Master wait: `stb_i`=0 with `cyc_i`=1 holds state and `baddr`; no beat completes.
  - Address check: if `adr_i` ≠ `baddr` at a beat, or `baddr` goes out of range, that beat is ERR-terminated instead and the FSM returns to IDLE.
- ERR: `err_o`=1 for one cycle, then IDLE. No memory write; `dat_o` is don't-care.
- Qualification: `ack_o` = `ack_r & cyc_i & stb_i`; `err_o` is likewise gated.
- Writes:
  - Performed at the edge where `ack_o`=1 and `we_i`=1.
  - Only lanes with `sel_i`[k]=1 are updated.
- Reads: `dat_o` = mem[index] of the current beat, registered.
- Abort: `cyc_i`=0 in any state returns the FSM to IDLE at the next edge. No write occurs.
- Memory contents are not affected by reset. Memory is preloadable via `$readmemh` on the array named `mem`.

## Timing
- Reset values: `ack_o`=0, `err_o`=0, `dat_o`=0, state IDLE, wait counter 0, `baddr`=0.
- Reset mid-transfer: outputs drop asynchronously; the in-flight write is dropped.
- Classic latency: request sampled at edge E0; `ack_o` is high in the cycle following edge E0+WAIT_STATES.
- Classic throughput: one transfer per WAIT_STATES+2 cycles.
- Burst: first beat has the same latency as classic. Each following beat is acked in consecutive cycles (1 beat/clk) while `stb_i`=1.
- `ack_o` and `err_o` are never high together.
- `err_o` latency equals ack latency.

## Structure
- Package `wb_pkg`:
  - CTI constants: `CTI_CLASSIC`, `CTI_INCR`, `CTI_EOB`.
  - BTE constants: `BTE_LINEAR`, `BTE_WRAP4`, `BTE_WRAP8`, `BTE_WRAP16`.
  - FSM state enum.
- Sub-module `wb_burst_addr`: combinational next-address generator (`baddr`, `bte`) → next `baddr`, parametrised by index width.

## Test plan
- WAIT_STATES=0: preload mem[3]=0xDEADBEEF; classic read of byte address 0xC → `ack_o` high in cycle E0+1, `dat_o`=0xDEADBEEF, then one idle cycle.
- Classic write of 0x11223344 to 0x10 with `sel_i`=0101, prior contents 0xAABBCCDD → readback 0xAA22CC44.
- Wrap-4 burst read starting at word 6, 4 beats, last beat `cti_i`=111 → beats read words 6,7,4,5 with `ack_o` high for 4 consecutive cycles, then 0.
- WAIT_STATES=3, MEM_WORDS=256: read of word 300 → `err_o` high exactly in cycle E0+4, `ack_o` never high, memory unchanged.
- Linear burst with master stall: `stb_i`=0 for 2 cycles mid-burst → no acks during the stall, `baddr` held, resumed beats continue at the next word. Also `adr_i` mismatch on a beat → `err_o` on that beat, FSM back to IDLE.
- `rst_n` asserted during the 2nd beat of a write burst → `ack_o`/`err_o` are 0 immediately. The 2nd word is unwritten and the 1st word is written. The next classic read after reset behaves normally.
